// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port from two producers.
// Optional WB_BYPASS_EN: an accepted request skips the queue when it is empty.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_reg,
  input  logic [WIDTH-1:0]         a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_reg,
  input  logic [WIDTH-1:0]         b_data,
  output logic                     ctrl_writeEnable,
  output logic [4:0]               ctrl_writeReg,
  output logic [WIDTH-1:0]         data_writeReg,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  logic [4:0]       regMem  [DEPTH];
  logic [WIDTH-1:0] dataMem [DEPTH];
  logic [PW-1:0]    head, tail, offs;
  logic             pushA, pushB, pop, bypass;
  logic             enq0, enq1;
  logic [4:0]       e0Reg, enq0Reg;
  logic [WIDTH-1:0] e0Data, enq0Data;

  assign a_ready = (count != CW'(DEPTH));
  assign b_ready = (CW1'(count) + CW1'(a_valid)) < CW1'(DEPTH);

  // r0 writes finish the handshake but never enter the queue
  always_comb begin
    pushA  = a_valid && a_ready && (a_reg != 5'd0);
    pushB  = b_valid && b_ready && (b_reg != 5'd0);
    pop    = (count != '0);
    e0Reg  = pushA ? a_reg  : b_reg;
    e0Data = pushA ? a_data : b_data;
`ifdef WB_BYPASS_EN
    bypass = (count == '0) && (pushA || pushB);
`else
    bypass = 1'b0;
`endif
    // when the first request bypasses, only B (if also pushed) is queued
    enq0     = bypass ? (pushA && pushB) : (pushA || pushB);
    enq1     = !bypass && pushA && pushB;
    enq0Reg  = bypass ? b_reg  : e0Reg;
    enq0Data = bypass ? b_data : e0Data;
  end

  always_ff @(posedge clock) begin
    if (enq0) begin
      regMem[tail]  <= enq0Reg;
      dataMem[tail] <= enq0Data;
    end
    if (enq1) begin
      regMem[tail + PW'(1)]  <= b_reg;
      dataMem[tail + PW'(1)] <= b_data;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      if (pop) begin
        head             <= head + PW'(1);
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= regMem[head];
        data_writeReg    <= dataMem[head];
      end else if (bypass) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= e0Reg;
        data_writeReg    <= e0Data;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
      tail  <= tail + PW'(enq0) + PW'(enq1);
      count <= count + CW'(enq0) + CW'(enq1) - CW'(pop);
    end
  end

  // an entry is live when its distance from head is below the occupancy
  always_comb begin
    pending = '0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      if (CW'(offs) < count) pending[regMem[i]] = 1'b1;
    end
    if (ctrl_writeEnable) pending[ctrl_writeReg] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized bench for regfile_writeback_queue against a queue-based reference model.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             ctrl_reset = 1'b1;
  logic             a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]       a_reg = '0, b_reg = '0;
  logic [WIDTH-1:0] a_data = '0, b_data = '0;
  logic             a_ready, b_ready, ctrl_writeEnable;
  logic [4:0]       ctrl_writeReg;
  logic [WIDTH-1:0] data_writeReg;
  logic [31:0]      pending;
  logic [$clog2(DEPTH):0] count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending(pending), .count(count));

  always #5 clock = ~clock;

  typedef struct { logic [4:0] r; logic [WIDTH-1:0] d; } ent_t;
  ent_t             mq[$];
  logic             mWe = 1'b0;
  logic [4:0]       mReg = '0;
  logic [WIDTH-1:0] mData = '0;
  int               nPass = 0, nTotal = 0;
  logic             checkEn = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task mClear();
    mq.delete();
    mWe = 1'b0;
    mReg = '0;
    mData = '0;
  endtask

  function automatic logic [31:0] mPending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].r] = 1'b1;
    if (mWe) p[mReg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // reference: retire the oldest pending write, then append accepted requests
  always @(posedge clock) begin
    if (!ctrl_reset) begin
      automatic int   pre  = mq.size();
      automatic logic aAcc = a_valid && (pre != DEPTH);
      automatic logic bAcc = b_valid && ((pre + int'(a_valid)) < DEPTH);
      automatic ent_t e;
      if (pre > 0) begin
        e = mq.pop_front();
        mWe = 1'b1; mReg = e.r; mData = e.d;
      end else mWe = 1'b0;
      if (aAcc && a_reg != 0) mq.push_back('{a_reg, a_data});
      if (bAcc && b_reg != 0) mq.push_back('{b_reg, b_data});
`ifdef WB_BYPASS_EN
      if (pre == 0 && mq.size() > 0) begin
        e = mq.pop_front();
        mWe = 1'b1; mReg = e.r; mData = e.d;
      end
`endif
    end
  end

  always @(negedge clock) begin
    if (checkEn && !ctrl_reset) begin
      chk("a_ready", a_ready, mq.size() != DEPTH);
      chk("b_ready", b_ready, (mq.size() + int'(a_valid)) < DEPTH);
      chk("count", count, mq.size());
      chk("writeEnable", ctrl_writeEnable, mWe);
      chk("writeReg", ctrl_writeReg, mReg);
      chk("writeData", data_writeReg, mData);
      chk("pending", pending, mPending());
    end
  end

  task automatic drive(input logic av, input logic [4:0] ar, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [4:0] br, input logic [WIDTH-1:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic step();
    @(negedge clock); #1;
  endtask

  task automatic doReset();
    @(posedge clock); #2;
    ctrl_reset = 1'b1;
    mClear();
    #1;
    chk("rst_count", count, 0);
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_wreg", ctrl_writeReg, 0);
    chk("rst_wdata", data_writeReg, 0);
    chk("rst_pending", pending, 0);
    @(negedge clock); #1;
    ctrl_reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("init_count", count, 0);
    chk("init_we", ctrl_writeEnable, 0);
    chk("init_pending", pending, 0);
    step();
    ctrl_reset = 1'b0;
    checkEn = 1'b1;

    // single A write to r5
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, '0);
    chk("t1_a_ready", a_ready, 1);
    step(); drive(0, 5'd0, '0, 0, 5'd0, '0);
`ifndef WB_BYPASS_EN
    chk("t1_count", count, 1);
    chk("t1_pend_q", pending[5], 1);
    step();
    chk("t1_we", ctrl_writeEnable, 1);
    chk("t1_reg", ctrl_writeReg, 5);
    chk("t1_data", data_writeReg, 32'hDEADBEEF);
    chk("t1_pend_out", pending[5], 1);
    step();
    chk("t1_we_off", ctrl_writeEnable, 0);
    chk("t1_pend_clr", pending, 0);
`else
    chk("t1b_count", count, 0);
    chk("t1b_we", ctrl_writeEnable, 1);
    chk("t1b_reg", ctrl_writeReg, 5);
    step();
`endif
    repeat (2) step();

    // A and B to the same register in one cycle
    drive(1, 5'd3, 32'd1, 1, 5'd3, 32'd2);
    step(); drive(0, 5'd0, '0, 0, 5'd0, '0);
`ifndef WB_BYPASS_EN
    chk("t2_count", count, 2);
    step();
    chk("t2_data1", data_writeReg, 1);
    chk("t2_pend1", pending[3], 1);
    step();
    chk("t2_data2", data_writeReg, 2);
    chk("t2_pend2", pending[3], 1);
    step();
    chk("t2_we_off", ctrl_writeEnable, 0);
    chk("t2_pend_clr", pending[3], 0);
`endif
    repeat (3) step();

    // r0 write is dropped
    drive(1, 5'd0, 32'h1234, 0, 5'd0, '0);
    chk("t3_a_ready", a_ready, 1);
    step(); drive(0, 5'd0, '0, 0, 5'd0, '0);
    chk("t3_count", count, 0);
    chk("t3_pending", pending, 0);
    step();
    chk("t3_we", ctrl_writeEnable, 0);

    // back-to-back dual pushes, distinct registers
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(2 * i + 10), 32'(100 + i), 1, 5'(2 * i + 11), 32'(200 + i));
      step();
    end
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    repeat (8) step();

    // async reset with three entries queued
    drive(1, 5'd20, 32'hA0, 1, 5'd21, 32'hB0);
    step();
    drive(1, 5'd22, 32'hA1, 1, 5'd23, 32'hB1);
    step();
    drive(0, 5'd0, '0, 0, 5'd0, '0);
`ifndef WB_BYPASS_EN
    chk("t5_count_pre", count, 3);
`endif
    doReset();
    repeat (2) step();
    chk("t5_no_strobe", ctrl_writeEnable, 0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 9)), $urandom);
      if ($urandom_range(0, 299) == 0) doReset();
      else step();
    end
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    repeat (6) step();
    chk("drain_count", count, 0);
    chk("drain_pending", pending, 0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end
endmodule
